// File: rtl/ysyx_22041207_axi_read_master_if.sv
// Bundle of upstream read-request signals and AXI4 AR/R channel signals.
// The master modport is the read master's view; the slave modport is the opposite view.
interface ysyx_22041207_axi_read_master_if #(
    parameter int RW_DATA_WIDTH  = 64,
    parameter int RW_ADDR_WIDTH  = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_USER_WIDTH = 1
);
    logic                      rw_valid_i;
    logic                      rw_ready_o;
    logic [RW_ADDR_WIDTH-1:0]  rw_addr_i;
    logic [7:0]                rw_size_i;
    logic [RW_DATA_WIDTH-1:0]  rw_data_o;
    logic [1:0]                rw_resp_o;
    logic                      rw_data_valid_o;
    logic                      rw_data_ready_i;

    logic                      axi_ar_valid_o;
    logic                      axi_ar_ready_i;
    logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr_o;
    logic [AXI_ID_WIDTH-1:0]   axi_ar_id_o;
    logic [7:0]                axi_ar_len_o;
    logic [2:0]                axi_ar_size_o;
    logic [1:0]                axi_ar_burst_o;
    logic [AXI_USER_WIDTH-1:0] axi_ar_user_o;

    logic                      axi_r_valid_i;
    logic                      axi_r_ready_o;
    logic [AXI_DATA_WIDTH-1:0] axi_r_data_i;
    logic [1:0]                axi_r_resp_i;
    logic                      axi_r_last_i;
    logic [AXI_ID_WIDTH-1:0]   axi_r_id_i;

    modport master (
        input  rw_valid_i, rw_addr_i, rw_size_i, rw_data_ready_i,
        output rw_ready_o, rw_data_o, rw_resp_o, rw_data_valid_o,
        output axi_ar_valid_o, axi_ar_addr_o, axi_ar_id_o, axi_ar_len_o,
        output axi_ar_size_o, axi_ar_burst_o, axi_ar_user_o,
        input  axi_ar_ready_i,
        input  axi_r_valid_i, axi_r_data_i, axi_r_resp_i, axi_r_last_i, axi_r_id_i,
        output axi_r_ready_o
    );

    modport slave (
        output rw_valid_i, rw_addr_i, rw_size_i, rw_data_ready_i,
        input  rw_ready_o, rw_data_o, rw_resp_o, rw_data_valid_o,
        input  axi_ar_valid_o, axi_ar_addr_o, axi_ar_id_o, axi_ar_len_o,
        input  axi_ar_size_o, axi_ar_burst_o, axi_ar_user_o,
        output axi_ar_ready_i,
        output axi_r_valid_i, axi_r_data_i, axi_r_resp_i, axi_r_last_i, axi_r_id_i,
        input  axi_r_ready_o
    );
endinterface

// File: rtl/ysyx_22041207_axi_read_master.sv
// Turns one upstream read request into a single-beat AXI4 read (AR then R) and
// returns the requested bytes right-aligned and zero-extended, with RRESP.
//
// state | meaning
// IDLE  | ready for a request; latches addr/size on rw_valid_i
// AR    | ARVALID held with latched addr until ARREADY
// R     | RREADY high; captures the beat on RVALID
// DONE  | data/resp presented upstream until rw_data_ready_i
module ysyx_22041207_axi_read_master #(
    parameter int RW_DATA_WIDTH  = 64,
    parameter int RW_ADDR_WIDTH  = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_USER_WIDTH = 1,
    parameter int AXI_ID         = 0
) (
    input logic clk,
    input logic rst,
    ysyx_22041207_axi_read_master_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e                   state_q, state_d;
    logic [RW_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]               size_q, size_d;
    logic [RW_DATA_WIDTH-1:0] data_q, data_d;
    logic [1:0]               resp_q, resp_d;

    logic [5:0]                shift_amt;
    logic [AXI_DATA_WIDTH-1:0] beat_shifted;
    logic [RW_DATA_WIDTH-1:0]  size_mask;
    logic [RW_DATA_WIDTH-1:0]  beat_data;
    logic [2:0]                ar_size;
    logic                      unused_ok;

    // Byte lane select; bytes shifted in past the top of the beat read as zero.
    always_comb begin
        shift_amt    = {addr_q[2:0], 3'b000};
        beat_shifted = bus.axi_r_data_i >> shift_amt;
        case (size_q)
            8'd1:    size_mask = RW_DATA_WIDTH'(8'hFF);
            8'd2:    size_mask = RW_DATA_WIDTH'(16'hFFFF);
            8'd4:    size_mask = RW_DATA_WIDTH'(32'hFFFF_FFFF);
            default: size_mask = '1;
        endcase
        beat_data = RW_DATA_WIDTH'(beat_shifted) & size_mask;
    end

    // Unrecognised sizes fall back to a full 8-byte access.
    always_comb begin
        case (size_q)
            8'd1:    ar_size = 3'd0;
            8'd2:    ar_size = 3'd1;
            8'd4:    ar_size = 3'd2;
            default: ar_size = 3'd3;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        data_d  = data_q;
        resp_d  = resp_q;
        case (state_q)
            S_IDLE: begin
                if (bus.rw_valid_i) begin
                    addr_d  = bus.rw_addr_i;
                    size_d  = bus.rw_size_i;
                    state_d = S_AR;
                end
            end
            S_AR: begin
                if (bus.axi_ar_ready_i) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                if (bus.axi_r_valid_i) begin
                    data_d  = beat_data;
                    resp_d  = bus.axi_r_resp_i;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.rw_data_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            data_q  <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            data_q  <= data_d;
            resp_q  <= resp_d;
        end
    end

    always_comb begin
        bus.rw_ready_o      = (state_q == S_IDLE);
        bus.rw_data_valid_o = (state_q == S_DONE);
        bus.rw_data_o       = data_q;
        bus.rw_resp_o       = resp_q;

        bus.axi_ar_valid_o  = (state_q == S_AR);
        bus.axi_ar_addr_o   = AXI_ADDR_WIDTH'(addr_q);
        bus.axi_ar_id_o     = AXI_ID_WIDTH'(AXI_ID);
        bus.axi_ar_len_o    = 8'd0;
        bus.axi_ar_size_o   = ar_size;
        bus.axi_ar_burst_o  = 2'b01;
        bus.axi_ar_user_o   = AXI_USER_WIDTH'(0);

        bus.axi_r_ready_o   = (state_q == S_R);
    end

    // RLAST/RID carry no information with a single outstanding single-beat read.
    assign unused_ok = ^{bus.axi_r_last_i, bus.axi_r_id_i};

endmodule

// File: tb/tb_ysyx_22041207_axi_read_master.sv
// Bench for the AXI single-beat read master: directed scenarios plus randomized
// reads against a byte-level reference model and a cycle-stepped slave.
module tb_ysyx_22041207_axi_read_master;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_22041207_axi_read_master_if bus ();

    ysyx_22041207_axi_read_master dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: pick size bytes starting at byte addr[2:0] of the beat.
    function automatic logic [63:0] exp_data(input logic [63:0] addr, input logic [7:0] size,
                                             input logic [63:0] rdata);
        int n;
        int off;
        logic [63:0] res;
        n   = (size == 8'd1 || size == 8'd2 || size == 8'd4) ? int'(size) : 8;
        off = int'(addr[2:0]);
        res = '0;
        for (int i = 0; i < n; i++) begin
            if (off + i < 8) res[8*i +: 8] = rdata[8*(off+i) +: 8];
        end
        return res;
    endfunction

    function automatic logic [2:0] exp_arsize(input logic [7:0] size);
        if (size == 8'd1) return 3'd0;
        if (size == 8'd2) return 3'd1;
        if (size == 8'd4) return 3'd2;
        return 3'd3;
    endfunction

    task automatic do_read(input logic [63:0] addr, input logic [7:0] size,
                           input logic [63:0] rdata, input logic [1:0] resp,
                           input int ar_dly, input int r_dly, input int d_dly);
        logic [63:0] ed;
        ed = exp_data(addr, size, rdata);
        chk("idle_ready", bus.rw_ready_o, 1);
        chk("idle_dv", bus.rw_data_valid_o, 0);
        bus.rw_valid_i = 1'b1;
        bus.rw_addr_i  = addr;
        bus.rw_size_i  = size;
        step();
        bus.rw_valid_i = 1'b0;
        bus.rw_addr_i  = {$urandom, $urandom};
        bus.rw_size_i  = 8'($urandom);
        chk("ar_valid", bus.axi_ar_valid_o, 1);
        chk("ar_addr", bus.axi_ar_addr_o, addr);
        chk("ar_size", bus.axi_ar_size_o, exp_arsize(size));
        chk("ar_len", bus.axi_ar_len_o, 0);
        chk("ar_id", bus.axi_ar_id_o, 0);
        chk("ar_burst", bus.axi_ar_burst_o, 1);
        chk("ar_user", bus.axi_ar_user_o, 0);
        chk("busy_ready", bus.rw_ready_o, 0);
        for (int k = 0; k < ar_dly; k++) begin
            bus.axi_ar_ready_i  = 1'b0;
            bus.rw_data_ready_i = 1'($urandom_range(0, 1));
            step();
            chk("ar_valid_hold", bus.axi_ar_valid_o, 1);
            chk("ar_addr_hold", bus.axi_ar_addr_o, addr);
            chk("r_ready_early", bus.axi_r_ready_o, 0);
        end
        bus.axi_ar_ready_i = 1'b1;
        step();
        bus.axi_ar_ready_i = 1'b0;
        chk("ar_one_hs", bus.axi_ar_valid_o, 0);
        chk("r_ready", bus.axi_r_ready_o, 1);
        chk("dv_early", bus.rw_data_valid_o, 0);
        for (int k = 0; k < r_dly; k++) begin
            bus.axi_r_valid_i   = 1'b0;
            bus.rw_data_ready_i = 1'($urandom_range(0, 1));
            step();
            chk("r_ready_hold", bus.axi_r_ready_o, 1);
            chk("dv_wait", bus.rw_data_valid_o, 0);
        end
        bus.axi_r_valid_i   = 1'b1;
        bus.axi_r_data_i    = rdata;
        bus.axi_r_resp_i    = resp;
        bus.axi_r_last_i    = 1'b1;
        bus.axi_r_id_i      = 4'($urandom);
        bus.rw_data_ready_i = 1'($urandom_range(0, 1));
        step();
        bus.axi_r_valid_i   = 1'b0;
        bus.axi_r_data_i    = {$urandom, $urandom};
        bus.axi_r_resp_i    = 2'($urandom);
        bus.rw_data_ready_i = 1'b0;
        chk("dv", bus.rw_data_valid_o, 1);
        chk("data", bus.rw_data_o, ed);
        chk("resp", bus.rw_resp_o, resp);
        chk("r_ready_drop", bus.axi_r_ready_o, 0);
        for (int k = 0; k < d_dly; k++) begin
            step();
            chk("dv_hold", bus.rw_data_valid_o, 1);
            chk("data_hold", bus.rw_data_o, ed);
            chk("resp_hold", bus.rw_resp_o, resp);
            chk("no_accept", bus.rw_ready_o, 0);
        end
        bus.rw_data_ready_i = 1'b1;
        step();
        bus.rw_data_ready_i = 1'b0;
        chk("dv_clear", bus.rw_data_valid_o, 0);
        chk("ready_back", bus.rw_ready_o, 1);
    endtask

    initial begin
        logic [7:0]  sizes [6];
        logic [63:0] addr;
        sizes = '{8'd1, 8'd2, 8'd4, 8'd8, 8'd3, 8'd0};
        rst = 1'b1;
        bus.rw_valid_i = 0; bus.rw_addr_i = 0; bus.rw_size_i = 0; bus.rw_data_ready_i = 0;
        bus.axi_ar_ready_i = 0; bus.axi_r_valid_i = 0; bus.axi_r_data_i = 0;
        bus.axi_r_resp_i = 0; bus.axi_r_last_i = 0; bus.axi_r_id_i = 0;
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_ready", bus.rw_ready_o, 1);
        chk("rst_ar_valid", bus.axi_ar_valid_o, 0);
        chk("rst_r_ready", bus.axi_r_ready_o, 0);
        chk("rst_dv", bus.rw_data_valid_o, 0);
        chk("rst_data", bus.rw_data_o, 0);
        chk("rst_resp", bus.rw_resp_o, 0);

        do_read(64'h8000_0000, 8'd8, 64'h1122_3344_5566_7788, 2'b00, 0, 0, 0);
        do_read(64'h8000_0005, 8'd1, 64'h1122_3344_5566_7788, 2'b00, 0, 0, 0);
        do_read(64'h8000_0002, 8'd2, 64'h1122_3344_5566_7788, 2'b00, 0, 0, 0);
        do_read(64'h8000_0010, 8'd8, 64'hDEAD_BEEF_CAFE_F00D, 2'b00, 4, 3, 0);
        do_read(64'h8000_0024, 8'd4, 64'hA5A5_5A5A_0123_4567, 2'b10, 0, 0, 5);
        do_read(64'h8000_0006, 8'd4, 64'hFFEE_DDCC_BBAA_9988, 2'b11, 1, 1, 1);

        // Reset while waiting for R: stray RVALID afterwards must be ignored.
        bus.rw_valid_i = 1'b1;
        bus.rw_addr_i  = 64'h8000_0040;
        bus.rw_size_i  = 8'd8;
        step();
        bus.rw_valid_i     = 1'b0;
        bus.axi_ar_ready_i = 1'b1;
        step();
        bus.axi_ar_ready_i = 1'b0;
        chk("pre_rst_r_ready", bus.axi_r_ready_o, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_ready", bus.rw_ready_o, 1);
        chk("mid_rst_ar_valid", bus.axi_ar_valid_o, 0);
        chk("mid_rst_r_ready", bus.axi_r_ready_o, 0);
        chk("mid_rst_dv", bus.rw_data_valid_o, 0);
        chk("mid_rst_data", bus.rw_data_o, 0);
        bus.axi_r_valid_i = 1'b1;
        bus.axi_r_data_i  = 64'h0BAD_0BAD_0BAD_0BAD;
        bus.axi_r_resp_i  = 2'b11;
        step();
        bus.axi_r_valid_i = 1'b0;
        chk("stray_r_dv", bus.rw_data_valid_o, 0);
        chk("stray_r_data", bus.rw_data_o, 0);
        chk("stray_r_ready", bus.rw_ready_o, 1);
        do_read(64'h8000_0003, 8'd2, 64'h0706_0504_0302_0100, 2'b00, 0, 2, 0);

        for (int t = 0; t < 40; t++) begin
            addr = {32'h0000_0000, 32'h8000_0000 | $urandom_range(0, 32'hFFFF)};
            do_read(addr, sizes[$urandom_range(0, 5)], {$urandom, $urandom}, 2'($urandom),
                    $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
